// File: rtl/decode_cycle_pkg.sv
// rtl/decode_cycle_pkg.sv - shared decode encodings, ID/EX record and helpers
// Purpose: opcode constants, ResultSrc/ImmSrc/ALUControl encodings, the ID/EX
//          pipeline record, and the ALU-select and immediate-extend helpers.
// Ports:   none (package).
package decode_cycle_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } idex_t;

    // sub_en is only ever set for R-type (funct7[5]); I-ALU addi has no subtract form.
    function automatic alu_ctrl_e alu_sel(input logic [2:0] funct3, input logic sub_en);
        alu_ctrl_e sel;
        case (funct3)
            3'b000: begin
                if (sub_en) sel = ALU_SUB;
                else        sel = ALU_ADD;
            end
            3'b010:  sel = ALU_SLT;
            3'b110:  sel = ALU_OR;
            3'b111:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    // Takes InstrD[31:7]; the opcode bits never contribute to an immediate.
    function automatic logic [31:0] imm_extend(input logic [31:7] i, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// rtl/decode_cycle_reg_file.sv - 32x32 register file, two async reads, one sync write
// Purpose: architectural registers x0..x31; x0 hardwired to zero.
//          Optional macro RF_BYPASS_EN: a read of the register being written
//          this cycle returns the write data (write-through).
// Ports:   clk, rst (sync, active-high, clears all registers),
//          ra1/ra2 -> rd1/rd2 (combinational reads), we/wa/wd (write port).
module decode_cycle_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
        rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
`ifdef RF_BYPASS_EN
        // wa != 0 in the match already excludes x0 from the bypass.
        if (we && (wa != 5'd0) && (wa == ra1)) rd1 = wd;
        if (we && (wa != 5'd0) && (wa == ra2)) rd2 = wd;
`endif
    end

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage with ID/EX pipeline register
// Purpose: decodes InstrD into control, reads the register file, sign-extends
//          the immediate and registers everything into ID/EX. Hosts the
//          writeback port of the register file (bypass via macro RF_BYPASS_EN).
// Ports:   clk, rst (sync active-high), en (0 = stall), clr (flush, beats en),
//          InstrD/PCD/PCPlus4D from IF/ID, RegWriteW/RdW/ResultW writeback,
//          Rs1D/Rs2D combinational to the hazard unit, *E registered outputs.
module decode_cycle
    import decode_cycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        IllegalE
);

    logic [31:0] rd1, rd2;
    logic        reg_write, mem_write, jump, branch, alu_src, illegal, imm_en;
    result_src_e result_src;
    imm_src_e    imm_src;
    alu_ctrl_e   alu_ctrl;
    logic [31:0] imm_ext;
    idex_t       idex_d, idex_q;

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    decode_cycle_reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra1 (InstrD[19:15]),
        .ra2 (InstrD[24:20]),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (RegWriteW),
        .wa  (RdW),
        .wd  (ResultW)
    );

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        illegal    = 1'b0;
        imm_en     = 1'b0;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        alu_ctrl   = ALU_ADD;
        case (InstrD[6:0])
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
                imm_en     = 1'b1;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
                imm_en    = 1'b1;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_sel(InstrD[14:12], InstrD[30]);
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_en    = 1'b1;
                alu_ctrl  = alu_sel(InstrD[14:12], 1'b0);
            end
            OP_BEQ: begin
                branch   = 1'b1;
                imm_src  = IMM_B;
                imm_en   = 1'b1;
                alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
                imm_en     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // R-type and illegal opcodes carry no immediate; drive zero.
        imm_ext = imm_en ? imm_extend(InstrD[31:7], imm_src) : 32'd0;
    end

    // rst is handled in the flop; here flush beats stall, stall holds.
    always_comb begin
        idex_d = idex_q;
        if (clr) begin
            idex_d = '0;
        end else if (en) begin
            idex_d.reg_write  = reg_write;
            idex_d.mem_write  = mem_write;
            idex_d.jump       = jump;
            idex_d.branch     = branch;
            idex_d.alu_src    = alu_src;
            idex_d.result_src = result_src;
            idex_d.alu_ctrl   = alu_ctrl;
            idex_d.rd1        = rd1;
            idex_d.rd2        = rd2;
            idex_d.imm_ext    = imm_ext;
            idex_d.pc         = PCD;
            idex_d.pc_plus4   = PCPlus4D;
            idex_d.rs1        = InstrD[19:15];
            idex_d.rs2        = InstrD[24:20];
            idex_d.rd         = InstrD[11:7];
            idex_d.illegal    = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm_ext;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - self-checking bench for decode_cycle
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        IllegalE;

    int n_checks = 0;
    int n_err    = 0;

    // Expected ID/EX contents and reference register file.
    logic        e_rw, e_mw, e_j, e_b, e_as, e_ill;
    logic [1:0]  e_rs;
    logic [2:0]  e_alu;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] mrf [32];

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .IllegalE(IllegalE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] s;
        s = v << (32 - bits);
        return 32'($signed(s) >>> (32 - bits));
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (RegWriteW && RdW == r) return ResultW;
`endif
        return mrf[r];
    endfunction

    task automatic zero_exp();
        {e_rw, e_mw, e_j, e_b, e_as, e_ill} = '0;
        e_rs = '0; e_alu = '0;
        {e_rd1, e_rd2, e_imm, e_pc, e_pc4} = '0;
        {e_rs1, e_rs2, e_rd} = '0;
    endtask

    // ALU op for arithmetic opcodes from the funct3/funct7 rules.
    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic is_sub);
        if (f3 == 3'd0) return is_sub ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    task automatic model_capture(input logic [31:0] ins);
        logic [31:0] imm_i, imm_s, imm_b, imm_j;
        zero_exp();
        imm_i = sext({20'd0, ins[31:20]}, 12);
        imm_s = sext({20'd0, ins[31:25], ins[11:7]}, 12);
        imm_b = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        imm_j = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        case (ins[6:0])
            7'b0000011: begin e_rw = 1; e_as = 1; e_rs = 2'b01; e_imm = imm_i; end
            7'b0100011: begin e_mw = 1; e_as = 1; e_imm = imm_s; end
            7'b0110011: begin e_rw = 1; e_alu = alu_of(ins[14:12], ins[30]); end
            7'b0010011: begin e_rw = 1; e_as = 1; e_imm = imm_i; e_alu = alu_of(ins[14:12], 1'b0); end
            7'b1100011: begin e_b = 1; e_imm = imm_b; e_alu = 3'b001; end
            7'b1101111: begin e_rw = 1; e_j = 1; e_rs = 2'b10; e_imm = imm_j; end
            default:    e_ill = 1;
        endcase
        e_rs1 = ins[19:15]; e_rs2 = ins[24:20]; e_rd = ins[11:7];
        e_rd1 = rf_read(ins[19:15]);
        e_rd2 = rf_read(ins[24:20]);
        e_pc = PCD; e_pc4 = PCPlus4D;
    endtask

    task automatic check_all(input string t);
        chk({t, ".RegWriteE"}, 32'(RegWriteE), 32'(e_rw));
        chk({t, ".MemWriteE"}, 32'(MemWriteE), 32'(e_mw));
        chk({t, ".JumpE"}, 32'(JumpE), 32'(e_j));
        chk({t, ".BranchE"}, 32'(BranchE), 32'(e_b));
        chk({t, ".ALUSrcE"}, 32'(ALUSrcE), 32'(e_as));
        chk({t, ".ResultSrcE"}, 32'(ResultSrcE), 32'(e_rs));
        chk({t, ".ALUControlE"}, 32'(ALUControlE), 32'(e_alu));
        chk({t, ".RD1E"}, RD1E, e_rd1);
        chk({t, ".RD2E"}, RD2E, e_rd2);
        chk({t, ".ImmExtE"}, ImmExtE, e_imm);
        chk({t, ".PCE"}, PCE, e_pc);
        chk({t, ".PCPlus4E"}, PCPlus4E, e_pc4);
        chk({t, ".Rs1E"}, 32'(Rs1E), 32'(e_rs1));
        chk({t, ".Rs2E"}, 32'(Rs2E), 32'(e_rs2));
        chk({t, ".RdE"}, 32'(RdE), 32'(e_rd));
        chk({t, ".IllegalE"}, 32'(IllegalE), 32'(e_ill));
    endtask

    // One clock: predict ID/EX and register file, advance, compare.
    task automatic step(input string t);
        chk({t, ".Rs1D"}, 32'(Rs1D), 32'(InstrD[19:15]));
        chk({t, ".Rs2D"}, 32'(Rs2D), 32'(InstrD[24:20]));
        if (rst || clr) zero_exp();
        else if (en) model_capture(InstrD);
        if (rst) begin
            for (int k = 0; k < 32; k++) mrf[k] = 32'd0;
        end else if (RegWriteW && RdW != 5'd0) begin
            mrf[RdW] = ResultW;
        end
        @(posedge clk);
        #1;
        check_all(t);
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [31:0] prev_x5;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        for (int k = 0; k < 32; k++) mrf[k] = $urandom;
        rst = 1; en = 0; clr = 0; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h4;
        RegWriteW = 0; RdW = 0; ResultW = 0;
        zero_exp();

        step("reset");
        rst = 0; en = 1;

        for (int r = 1; r < 32; r++) begin
            InstrD = {7'd0, 5'(r), 5'(r), 3'd0, 5'd1, 7'b0110011};
            step("rf_after_reset");
            chk("rf_zero", RD1E, 32'd0);
        end

        PCD = 32'h0000_0100; PCPlus4D = 32'h0000_0104;
        InstrD = 32'h00500293;
        step("addi");
        chk("addi.imm", ImmExtE, 32'h5);
        chk("addi.rd", 32'(RdE), 32'd5);
        chk("addi.ctl", {29'd0, RegWriteE, ALUSrcE, MemWriteE}, 32'b110);

        InstrD = 32'hFFC2A303;
        step("lw");
        chk("lw.rsrc", 32'(ResultSrcE), 32'b01);
        chk("lw.imm", ImmExtE, 32'hFFFFFFFC);

        InstrD = 32'h0062A423;
        step("sw");
        chk("sw.memwr", {30'd0, MemWriteE, RegWriteE}, 32'b10);
        chk("sw.imm", ImmExtE, 32'h8);

        RegWriteW = 1; RdW = 5; ResultW = 32'h1111_1111;
        step("wb_x5");
        prev_x5 = 32'h1111_1111;
        RdW = 5; ResultW = 32'hDEADBEEF; InstrD = 32'hFFC2A303;
        step("bypass");
`ifdef RF_BYPASS_EN
        chk("bypass.rd1", RD1E, 32'hDEADBEEF);
`else
        chk("bypass.rd1", RD1E, prev_x5);
`endif
        RdW = 0; ResultW = 32'hCAFEF00D; InstrD = 32'h000000B3;
        step("wb_x0");
        RegWriteW = 0;
        step("read_x0");
        chk("x0.rd1", RD1E, 32'd0);

        InstrD = 32'h0062A423;
        step("pre_stall");
        en = 0; InstrD = 32'h00500293;
        step("stall1");
        InstrD = 32'h0000007F;
        step("stall2");
        chk("stall.memwr", 32'(MemWriteE), 32'd1);
        clr = 1;
        step("flush");
        chk("flush.pc", PCE, 32'd0);
        clr = 0; en = 1;

        step("illegal");
        chk("illegal.flag", 32'(IllegalE), 32'd1);
        chk("illegal.ctl", {28'd0, RegWriteE, MemWriteE, BranchE, JumpE}, 32'd0);

        InstrD = 32'h00500293;
        step("pre_rst");
        rst = 1;
        step("mid_rst");
        rst = 0;

        for (int c = 0; c < 400; c++) begin
            int idx;
            idx = $urandom_range(0, 6);
            InstrD = $urandom;
            if (idx < 6) InstrD[6:0] = ops[idx];
            PCD = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            PCPlus4D = PCD + 32'd4;
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 63) == 0);
            RegWriteW = $urandom_range(0, 1);
            RdW = $urandom_range(0, 31);
            ResultW = $urandom;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
